// File: rtl/spi_fl_pkg.sv
// Shared constants, commtype encodings and sequencer state type for the SPI flash controller.
package spi_fl_pkg;

  localparam logic [7:0] FL_CMD_READ = 8'h03;
  localparam logic [7:0] FL_CMD_WREN = 8'h06;
  localparam logic [7:0] FL_CMD_PP   = 8'h02;
  localparam logic [7:0] FL_CMD_RDSR = 8'h05;

  localparam logic [2:0] CT_CMD     = 3'b000;
  localparam logic [2:0] CT_ADDR_RD = 3'b001;
  localparam logic [2:0] CT_ADDR_WR = 3'b010;
  localparam logic [2:0] CT_REG_RD  = 3'b011;

  typedef enum logic [3:0] {
    StIdle,
    StRdIss,
    StRdWt,
    StWenIss,
    StWenWt,
    StPpIss,
    StPpWt,
    StSrIss,
    StSrWt,
    StDone
  } state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_fl_issue.sv
// Handshake helper toward spi_master_fl: holds one command request, fires it when the
// master is ready and reports completion.
module spi_fl_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [7:0]  command,
  input  logic [23:0] address,
  input  logic [31:0] data,
  input  logic [2:0]  commtype,
  input  logic        issue,
  input  logic        waiting,
  input  logic        fl_tready,
  input  logic        fl_validflag_out,
  output logic [7:0]  fl_command,
  output logic [23:0] fl_address,
  output logic [31:0] fl_data_in,
  output logic [2:0]  fl_commtype,
  output logic        fl_validflag,
  output logic        fire,
  output logic        done
);

  assign fire = issue & fl_tready;
  assign done = waiting & fl_validflag_out;

  // Request buses only change on load, so they stay stable through the wait phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_command   <= '0;
      fl_address   <= '0;
      fl_data_in   <= '0;
      fl_commtype  <= '0;
      fl_validflag <= 1'b0;
    end else begin
      if (load) begin
        fl_command  <= command;
        fl_address  <= address;
        fl_data_in  <= data;
        fl_commtype <= commtype;
      end
      fl_validflag <= fire;
    end
  end

endmodule

// File: rtl/spi_fl_ctrl.sv
// Word-level bus to SPI flash command sequencer: READ for loads; WREN, PAGE PROGRAM and
// RDSR polling (with timeout) for stores.
module spi_fl_ctrl
  import spi_fl_pkg::*;
#(
  parameter logic [15:0] POLL_MAX  = 16'd50000,
  parameter bit          BYTE_SWAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        we,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [7:0]  fl_command,
  output logic [23:0] fl_address,
  output logic [31:0] fl_data_in,
  output logic [2:0]  fl_commtype,
  output logic        fl_validflag,
  input  logic        fl_tready,
  input  logic        fl_validflag_out,
  input  logic [31:0] fl_data_out
);

  state_e      state_q, state_d;
  logic [21:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        busy_q;
  logic [15:0] poll_q;

  logic        load;
  logic [7:0]  ld_cmd;
  logic [23:0] ld_addr;
  logic [31:0] ld_data;
  logic [2:0]  ld_ct;
  logic        issue, waiting, fire, done;
  logic        poll_last;
  logic        unused_addr;

  assign unused_addr = ^addr[1:0];
  assign issue   = state_q inside {StRdIss, StWenIss, StPpIss, StSrIss};
  assign waiting = state_q inside {StRdWt, StWenWt, StPpWt, StSrWt};
  assign poll_last = (poll_q == POLL_MAX);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (valid) state_d = we ? StWenIss : StRdIss;
      StRdIss:  if (fire) state_d = StRdWt;
      StRdWt:   if (done) state_d = StDone;
      StWenIss: if (fire) state_d = StWenWt;
      StWenWt:  if (done) state_d = StPpIss;
      StPpIss:  if (fire) state_d = StPpWt;
      StPpWt:   if (done) state_d = StSrIss;
      StSrIss:  if (fire) state_d = StSrWt;
      StSrWt: begin
        if (done) state_d = (!fl_data_out[0] || poll_last) ? StDone : StSrIss;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Command fields are loaded on entry to each issue state.
  always_comb begin
    load    = 1'b0;
    ld_cmd  = '0;
    ld_addr = '0;
    ld_data = '0;
    ld_ct   = CT_CMD;
    if (state_d != state_q) begin
      case (state_d)
        StRdIss: begin
          load    = 1'b1;
          ld_cmd  = FL_CMD_READ;
          ld_addr = {addr[23:2], 2'b00};
          ld_ct   = CT_ADDR_RD;
        end
        StWenIss: begin
          load   = 1'b1;
          ld_cmd = FL_CMD_WREN;
          ld_ct  = CT_CMD;
        end
        StPpIss: begin
          load    = 1'b1;
          ld_cmd  = FL_CMD_PP;
          ld_addr = {addr_q, 2'b00};
          ld_data = wdata_q;
          ld_ct   = CT_ADDR_WR;
        end
        StSrIss: begin
          load   = 1'b1;
          ld_cmd = FL_CMD_RDSR;
          ld_ct  = CT_REG_RD;
        end
        default: load = 1'b0;
      endcase
    end
  end

  spi_fl_issue u_issue (
    .clk              (clk),
    .rst_n            (rst_n),
    .load             (load),
    .command          (ld_cmd),
    .address          (ld_addr),
    .data             (ld_data),
    .commtype         (ld_ct),
    .issue            (issue),
    .waiting          (waiting),
    .fl_tready        (fl_tready),
    .fl_validflag_out (fl_validflag_out),
    .fl_command       (fl_command),
    .fl_address       (fl_address),
    .fl_data_in       (fl_data_in),
    .fl_commtype      (fl_commtype),
    .fl_validflag     (fl_validflag),
    .fire             (fire),
    .done             (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      poll_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && valid) begin
        addr_q  <= addr[23:2];
        wdata_q <= BYTE_SWAP ? bswap32(wdata) : wdata;
        busy_q  <= 1'b1;
        err_q   <= 1'b0;
      end
      if (state_q == StSrIss && fire) poll_q <= poll_q + 16'd1;
      if (state_q == StRdWt && done) begin
        rdata_q <= BYTE_SWAP ? bswap32(fl_data_out) : fl_data_out;
      end
      if (state_q == StSrWt && done && fl_data_out[0] && poll_last) err_q <= 1'b1;
      if (state_q == StDone) begin
        busy_q <= 1'b0;
        poll_q <= '0;
      end
    end
  end

  assign ready = (state_q == StDone);
  assign rdata = rdata_q;
  assign err   = ready & err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_spi_fl_ctrl.sv
// Scoreboard bench for spi_fl_ctrl with a behavioural spi_master_fl model.
module tb_spi_fl_ctrl;
  import spi_fl_pkg::*;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        we = 1'b0;
  logic [23:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, err, busy, fl_validflag;
  logic [31:0] rdata, fl_data_in;
  logic [7:0]  fl_command;
  logic [23:0] fl_address;
  logic [2:0]  fl_commtype;
  logic        fl_tready;
  logic        fl_validflag_out = 1'b0;
  logic [31:0] fl_data_out = '0;

  always #5 clk = ~clk;

  spi_fl_ctrl #(
    .POLL_MAX  (16'd4),
    .BYTE_SWAP (1'b1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid            (valid),
    .we               (we),
    .addr             (addr),
    .wdata            (wdata),
    .ready            (ready),
    .rdata            (rdata),
    .err              (err),
    .busy             (busy),
    .fl_command       (fl_command),
    .fl_address       (fl_address),
    .fl_data_in       (fl_data_in),
    .fl_commtype      (fl_commtype),
    .fl_validflag     (fl_validflag),
    .fl_tready        (fl_tready),
    .fl_validflag_out (fl_validflag_out),
    .fl_data_out      (fl_data_out)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] adr;
    logic [31:0] dat;
    logic [2:0]  ct;
    bit          ck_adr;
    bit          ck_dat;
  } iss_t;

  typedef struct {
    logic [31:0] rd;
    bit          ck_rd;
    logic        er;
  } rsp_t;

  iss_t exp_iss[$];
  rsp_t exp_rsp[$];
  iss_t mon_e;
  rsp_t mon_r;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_pulse = 0;
  int   cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_iss(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d,
                          input logic [2:0] t, input bit ca, input bit cd);
    iss_t e;
    e.cmd = c; e.adr = a; e.dat = d; e.ct = t; e.ck_adr = ca; e.ck_dat = cd;
    exp_iss.push_back(e);
  endtask

  task automatic push_rsp(input logic [31:0] d, input bit cr, input logic e);
    rsp_t r;
    r.rd = d; r.ck_rd = cr; r.er = e;
    exp_rsp.push_back(r);
  endtask

  // Master model: accepts a pulse, stays busy LAT cycles, then returns a done pulse.
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_resp = '0;
  logic [31:0] rd_word = '0;
  int          wip_left = 0;
  bit          wip_inf = 1'b0;
  bit          tr_block = 1'b0;

  assign fl_tready = !m_busy && !fl_validflag_out && !tr_block;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      fl_validflag_out = 1'b0;
    end else begin
      fl_validflag_out = 1'b0;
      if (m_busy) begin
        if (m_cnt == 0) begin
          fl_data_out = m_resp;
          fl_validflag_out = 1'b1;
          m_busy = 1'b0;
        end else begin
          m_cnt--;
        end
      end else if (fl_validflag) begin
        m_busy = 1'b1;
        m_cnt = LAT;
        if (fl_command == 8'h03) begin
          m_resp = rd_word;
        end else if (fl_command == 8'h05) begin
          if (wip_inf || wip_left > 0) begin
            m_resp = 32'd1;
            if (wip_left > 0) wip_left--;
          end else begin
            m_resp = 32'd0;
          end
        end else begin
          m_resp = '0;
        end
      end
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (fl_validflag) begin
        n_pulse++;
        if (exp_iss.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_issue: got cmd %h expected none", fl_command);
        end else begin
          mon_e = exp_iss.pop_front();
          chk("iss_cmd", 32'(fl_command), 32'(mon_e.cmd));
          chk("iss_ct", 32'(fl_commtype), 32'(mon_e.ct));
          if (mon_e.ck_adr) chk("iss_addr", 32'(fl_address), 32'(mon_e.adr));
          if (mon_e.ck_dat) chk("iss_data", fl_data_in, mon_e.dat);
        end
      end
      if (ready) begin
        if (exp_rsp.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ready: got ready expected none");
        end else begin
          mon_r = exp_rsp.pop_front();
          chk("rsp_err", 32'(err), 32'(mon_r.er));
          if (mon_r.ck_rd) chk("rsp_rdata", rdata, mon_r.rd);
        end
      end
    end
  end

  task automatic wait_ready(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: got no ready expected ready within %0d cycles", budget);
    end
  endtask

  task automatic req(input logic w, input logic [23:0] a, input logic [31:0] d);
    @(negedge clk);
    valid = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    wait_ready(400);
    valid = 1'b0;
  endtask

  task automatic push_write(input logic [23:0] a, input logic [31:0] d, input int polls);
    push_iss(8'h06, 24'h0, 32'h0, 3'b000, 1'b0, 1'b0);
    push_iss(8'h02, a, d, 3'b010, 1'b1, 1'b1);
    for (int i = 0; i < polls; i++) push_iss(8'h05, 24'h0, 32'h0, 3'b011, 1'b0, 1'b0);
  endtask

  initial begin
    int  p0;
    int  t1;
    int  t2;
    bit  found;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_validflag", 32'(fl_validflag), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_command", 32'(fl_command), 32'd0);
    chk("rst_address", 32'(fl_address), 32'd0);
    chk("rst_data_in", fl_data_in, 32'd0);
    chk("rst_commtype", 32'(fl_commtype), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read
    rd_word = 32'hA0A0A0A3;
    push_iss(8'h03, 24'h555554, 32'h0, 3'b001, 1'b1, 1'b0);
    push_rsp(32'hA3A0A0A0, 1'b1, 1'b0);
    req(1'b0, 24'h555557, 32'h0);

    // Write with three busy polls
    wip_left = 3;
    p0 = n_pulse;
    push_write(24'h001000, 32'h5A000000, 4);
    push_rsp(32'h0, 1'b0, 1'b0);
    req(1'b1, 24'h001003, 32'h0000005A);
    chk("write_pulse_count", 32'(n_pulse - p0), 32'd6);

    // Poll timeout
    wip_inf = 1'b1;
    push_write(24'h002000, 32'h44332211, 4);
    push_rsp(32'h0, 1'b0, 1'b1);
    @(negedge clk);
    valid = 1'b1; we = 1'b1; addr = 24'h002002; wdata = 32'h11223344;
    wait_ready(400);
    chk("busy_at_ready", 32'(busy), 32'd1);
    valid = 1'b0;
    @(negedge clk);
    chk("busy_after_ready", 32'(busy), 32'd0);
    chk("err_after_ready", 32'(err), 32'd0);
    wip_inf = 1'b0;

    // Master not ready for 10 cycles
    tr_block = 1'b1;
    rd_word = 32'h12345678;
    push_iss(8'h03, 24'h000100, 32'h0, 3'b001, 1'b1, 1'b0);
    push_rsp(32'h78563412, 1'b1, 1'b0);
    p0 = n_pulse;
    @(negedge clk);
    valid = 1'b1; we = 1'b0; addr = 24'h000102;
    repeat (10) @(negedge clk);
    chk("no_pulse_tready_low", 32'(n_pulse - p0), 32'd0);
    tr_block = 1'b0;
    wait_ready(400);
    valid = 1'b0;
    chk("one_pulse_after_tready", 32'(n_pulse - p0), 32'd1);

    // Reset during the first status poll
    wip_inf = 1'b1;
    push_write(24'h000200, 32'hEFBEADDE, 1);
    @(negedge clk);
    valid = 1'b1; we = 1'b1; addr = 24'h000200; wdata = 32'hDEADBEEF;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fl_validflag && fl_command == 8'h05) begin
        found = 1'b1;
        break;
      end
    end
    chk("rdsr_reached", 32'(found), 32'd1);
    valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_validflag", 32'(fl_validflag), 32'd0);
    chk("midrst_command", 32'(fl_command), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wip_inf = 1'b0;

    // Read after reset
    rd_word = 32'hCAFEBABE;
    push_iss(8'h03, 24'h000300, 32'h0, 3'b001, 1'b1, 1'b0);
    push_rsp(32'hBEBAFECA, 1'b1, 1'b0);
    req(1'b0, 24'h000301, 32'h0);

    // Back-to-back reads with valid held high
    rd_word = 32'h01020304;
    push_iss(8'h03, 24'h000400, 32'h0, 3'b001, 1'b1, 1'b0);
    push_iss(8'h03, 24'h000800, 32'h0, 3'b001, 1'b1, 1'b0);
    push_rsp(32'h04030201, 1'b1, 1'b0);
    push_rsp(32'h04030201, 1'b1, 1'b0);
    p0 = n_pulse;
    @(negedge clk);
    valid = 1'b1; we = 1'b0; addr = 24'h000400;
    wait_ready(400);
    t1 = cyc;
    addr = 24'h000800;
    @(negedge clk);
    chk("b2b_ready_one_cycle", 32'(ready), 32'd0);
    wait_ready(400);
    t2 = cyc;
    valid = 1'b0;
    chk("b2b_gap", 32'((t2 - t1) > LAT), 32'd1);
    chk("b2b_pulse_count", 32'(n_pulse - p0), 32'd2);

    repeat (20) @(negedge clk);
    chk("iss_queue_empty", 32'(exp_iss.size()), 32'd0);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
